// File: rtl/oam_dma_writer_if.sv
// CPU-bus, DMA and primary-OAM signal bundle for oam_dma_writer.
// The slave modport is the writer itself; the master modport is the CPU/bus/OAM side.
interface oam_dma_writer_if;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_we;
  logic        cpu_re;
  logic [7:0]  cpu_rdata;
  logic        cpu_halt;
  logic [15:0] dma_addr;
  logic        dma_rd;
  logic [7:0]  dma_rdata;
  logic [7:0]  oam_addr;
  logic [7:0]  oam_wdata;
  logic        oam_we;
  logic [7:0]  oam_rdata;

  modport slave (
    input  cpu_ce, cpu_addr, cpu_wdata, cpu_we, cpu_re, dma_rdata, oam_rdata,
    output cpu_rdata, cpu_halt, dma_addr, dma_rd, oam_addr, oam_wdata, oam_we
  );

  modport master (
    output cpu_ce, cpu_addr, cpu_wdata, cpu_we, cpu_re, dma_rdata, oam_rdata,
    input  cpu_rdata, cpu_halt, dma_addr, dma_rd, oam_addr, oam_wdata, oam_we
  );
endinterface

// File: rtl/oam_dma_writer.sv
// CPU OAMADDR/OAMDATA port and $4014 sprite DMA (513 CPU cycles; 514 on an odd start when
// OAM_DMA_ODD_ALIGN_EN is defined). All state advances on cpu_ce; the CPU is stalled via cpu_halt.
module oam_dma_writer #(
  parameter logic [15:0] DMA_REG     = 16'h4014,
  parameter logic [2:0]  OAMADDR_IDX = 3'd3,
  parameter logic [2:0]  OAMDATA_IDX = 3'd4
) (
  input  logic            clk,
  input  logic            reset,
  oam_dma_writer_if.slave bus
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t      state_q;
  logic [7:0]  oamaddr_q, oamaddr_d;
  logic [7:0]  cnt_q;
  logic [7:0]  page_q;
  logic [7:0]  byte_q;
  logic        parity_q;
  logic        cpu_halt_q;
  logic        dma_rd_q;
  logic [15:0] dma_addr_q;
  logic        oam_we_q;
  logic [7:0]  oam_addr_q;
  logic [7:0]  oam_wdata_q;
  logic [7:0]  cpu_rdata_q;

  logic ppu_sel, cpu_idle;
  logic wr_oamaddr, wr_oamdata, rd_oamdata, wr_dma;

  // Register accesses are only honoured while the DMA engine is idle.
  assign cpu_idle   = bus.cpu_ce && (state_q == IDLE);
  assign ppu_sel    = (bus.cpu_addr[15:13] == 3'b001);
  assign wr_oamaddr = cpu_idle && bus.cpu_we && ppu_sel && (bus.cpu_addr[2:0] == OAMADDR_IDX);
  assign wr_oamdata = cpu_idle && bus.cpu_we && ppu_sel && (bus.cpu_addr[2:0] == OAMDATA_IDX);
  assign rd_oamdata = cpu_idle && bus.cpu_re && ppu_sel && (bus.cpu_addr[2:0] == OAMDATA_IDX);
  assign wr_dma     = cpu_idle && bus.cpu_we && (bus.cpu_addr == DMA_REG);

  always_comb begin
    oamaddr_d = oamaddr_q;
    if (wr_oamaddr) begin
      oamaddr_d = bus.cpu_wdata;
    end else if (wr_oamdata || (bus.cpu_ce && state_q == WRITE)) begin
      oamaddr_d = oamaddr_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      oamaddr_q   <= 8'h00;
      cnt_q       <= 8'h00;
      page_q      <= 8'h00;
      byte_q      <= 8'h00;
      parity_q    <= 1'b0;
      cpu_halt_q  <= 1'b0;
      dma_rd_q    <= 1'b0;
      dma_addr_q  <= 16'h0000;
      oam_we_q    <= 1'b0;
      oam_addr_q  <= 8'h00;
      oam_wdata_q <= 8'h00;
      cpu_rdata_q <= 8'h00;
    end else begin
      oam_we_q  <= 1'b0;
      oamaddr_q <= oamaddr_d;
      // Between writes the OAM port follows the register so reads see the new address at once.
      oam_addr_q <= oamaddr_d;
      if (bus.cpu_ce) begin
        parity_q <= ~parity_q;
        case (state_q)
          IDLE: begin
            if (wr_dma) begin
              page_q     <= bus.cpu_wdata;
              cnt_q      <= 8'h00;
              cpu_halt_q <= 1'b1;
              state_q    <= HALT;
            end else if (wr_oamdata) begin
              oam_we_q    <= 1'b1;
              oam_addr_q  <= oamaddr_q;
              oam_wdata_q <= bus.cpu_wdata;
            end else if (rd_oamdata) begin
              cpu_rdata_q <= bus.oam_rdata;
            end
          end
          HALT: begin
`ifdef OAM_DMA_ODD_ALIGN_EN
            // Parity after this cycle is ~parity_q; an odd result needs one more dummy cycle.
            if (!parity_q) begin
              state_q <= ALIGN;
            end else begin
              dma_rd_q   <= 1'b1;
              dma_addr_q <= {page_q, cnt_q};
              state_q    <= READ;
            end
`else
            dma_rd_q   <= 1'b1;
            dma_addr_q <= {page_q, cnt_q};
            state_q    <= READ;
`endif
          end
          ALIGN: begin
            dma_rd_q   <= 1'b1;
            dma_addr_q <= {page_q, cnt_q};
            state_q    <= READ;
          end
          READ: begin
            byte_q   <= bus.dma_rdata;
            dma_rd_q <= 1'b0;
            state_q  <= WRITE;
          end
          WRITE: begin
            oam_we_q    <= 1'b1;
            oam_addr_q  <= oamaddr_q;
            oam_wdata_q <= byte_q;
            cnt_q       <= cnt_q + 8'd1;
            if (cnt_q == 8'hFF) begin
              cpu_halt_q <= 1'b0;
              state_q    <= IDLE;
            end else begin
              dma_rd_q   <= 1'b1;
              dma_addr_q <= {page_q, cnt_q + 8'd1};
              state_q    <= READ;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign bus.cpu_rdata = cpu_rdata_q;
  assign bus.cpu_halt  = cpu_halt_q;
  assign bus.dma_addr  = dma_addr_q;
  assign bus.dma_rd    = dma_rd_q;
  assign bus.oam_addr  = oam_addr_q;
  assign bus.oam_wdata = oam_wdata_q;
  assign bus.oam_we    = oam_we_q;

endmodule

// File: tb/tb_oam_dma_writer.sv
// Directed bench for oam_dma_writer: CPU register port, DMA length/addressing, OAM wrap, reset mid-DMA.
module tb_oam_dma_writer;

  logic clk;
  logic reset;

  oam_dma_writer_if bus ();

  oam_dma_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // CPU memory image seen by the DMA
  function automatic logic [7:0] mem_byte(input logic [15:0] a);
    return a[7:0] ^ a[15:8] ^ 8'h5A;
  endfunction

  // Primary OAM model: async read, written by the DUT's oam_we strobe
  logic [7:0] oam [256];
  bit         init_done = 1'b0;
  logic [7:0] log_a[$];
  logic [7:0] log_d[$];
  bit         we_prev = 1'b0;
  int         width_bad = 0;

  assign bus.oam_rdata = oam[bus.oam_addr];
  assign bus.dma_rdata = mem_byte(bus.dma_addr);

  always @(posedge clk) begin
    if (!init_done) begin
      for (int i = 0; i < 256; i++) oam[i] <= 8'(i) ^ 8'hC3;
      init_done <= 1'b1;
    end else if (bus.oam_we) begin
      oam[bus.oam_addr] <= bus.oam_wdata;
      log_a.push_back(bus.oam_addr);
      log_d.push_back(bus.oam_wdata);
      if (we_prev) width_bad++;
    end
    we_prev = bus.oam_we;
  end

  int          ce_count = 0;
  int          halt_ces = 0;
  int          dma_bad  = 0;
  logic [15:0] exp_addr = 16'h0;
  bit          seen_rd  = 1'b0;
  logic [15:0] first_rd = 16'h0;

  // One CPU cycle: cpu_ce high for one clk, then two clks low.
  task automatic cpu_cycle(input logic we, input logic re, input logic [15:0] addr, input logic [7:0] wd);
    @(negedge clk);
    bus.cpu_we    = we;
    bus.cpu_re    = re;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    bus.cpu_ce    = 1'b1;
    if (bus.cpu_halt) halt_ces++;
    if (bus.dma_rd) begin
      if (!seen_rd) begin
        first_rd = bus.dma_addr;
        seen_rd  = 1'b1;
      end
      if (bus.dma_addr !== exp_addr) dma_bad++;
      exp_addr++;
    end
    @(posedge clk);
    #1;
    bus.cpu_ce = 1'b0;
    bus.cpu_we = 1'b0;
    bus.cpu_re = 1'b0;
    ce_count++;
    @(posedge clk);
    @(posedge clk);
  endtask

  task automatic align_parity(input bit odd);
    if (ce_count[0] != odd) cpu_cycle(1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  task automatic start_dma(input logic [7:0] page);
    exp_addr = {page, 8'h00};
    halt_ces = 0;
    dma_bad  = 0;
    seen_rd  = 1'b0;
    log_a.delete();
    log_d.delete();
    cpu_cycle(1'b1, 1'b0, 16'h4014, page);
  endtask

  task automatic run_dma(input logic [7:0] page, input bit inject, output int len);
    int guard;
    start_dma(page);
    guard = 0;
    do begin
      if (inject && guard == 10)      cpu_cycle(1'b1, 1'b0, 16'h2003, 8'h55);
      else if (inject && guard == 20) cpu_cycle(1'b1, 1'b0, 16'h4014, 8'h07);
      else                            cpu_cycle(1'b0, 1'b0, 16'h0000, 8'h00);
      guard++;
    end while (bus.cpu_halt && guard < 2000);
    check("dma_done", int'(bus.cpu_halt), 0);
    len = halt_ces;
  endtask

  function automatic int oam_errs(input logic [7:0] start, input logic [7:0] page);
    int e = 0;
    for (int i = 0; i < 256; i++) begin
      if (oam[8'(start + 8'(i))] !== mem_byte({page, 8'(i)})) e++;
    end
    return e;
  endfunction

  int len;
  int exp_odd_len;

  initial begin
`ifdef OAM_DMA_ODD_ALIGN_EN
    exp_odd_len = 514;
`else
    exp_odd_len = 513;
`endif
    bus.cpu_ce    = 1'b0;
    bus.cpu_we    = 1'b0;
    bus.cpu_re    = 1'b0;
    bus.cpu_addr  = 16'h0000;
    bus.cpu_wdata = 8'h00;
    reset = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("rst_cpu_halt",  int'(bus.cpu_halt),  0);
    check("rst_dma_rd",    int'(bus.dma_rd),    0);
    check("rst_dma_addr",  int'(bus.dma_addr),  0);
    check("rst_oam_we",    int'(bus.oam_we),    0);
    check("rst_oam_addr",  int'(bus.oam_addr),  0);
    check("rst_oam_wdata", int'(bus.oam_wdata), 0);
    check("rst_cpu_rdata", int'(bus.cpu_rdata), 0);
    @(negedge clk);
    reset = 1'b0;

    // OAMADDR / OAMDATA writes
    log_a.delete();
    log_d.delete();
    cpu_cycle(1'b1, 1'b0, 16'h2003, 8'h10);
    cpu_cycle(1'b1, 1'b0, 16'h2004, 8'hAB);
    check("wr1_count", log_a.size(), 1);
    check("wr1_addr",  int'(log_a[0]), 8'h10);
    check("wr1_data",  int'(log_d[0]), 8'hAB);
    cpu_cycle(1'b1, 1'b0, 16'h2004, 8'hCD);
    check("wr2_addr",  int'(log_a[1]), 8'h11);
    check("wr2_data",  int'(log_d[1]), 8'hCD);
    check("we_width",  width_bad, 0);

    // Mirrored OAMADDR write, reads do not increment
    cpu_cycle(1'b1, 1'b0, 16'h200B, 8'h20);
    cpu_cycle(1'b0, 1'b1, 16'h2004, 8'h00);
    check("rd1_oam_addr", int'(bus.oam_addr),  8'h20);
    check("rd1_data",     int'(bus.cpu_rdata), 8'hE3);
    cpu_cycle(1'b0, 1'b1, 16'h3FFC, 8'h00);
    check("rd2_oam_addr", int'(bus.oam_addr),  8'h20);
    check("rd2_data",     int'(bus.cpu_rdata), 8'hE3);

    // Even-start DMA from page 0x02, oamaddr = 0x20
    align_parity(1'b0);
    run_dma(8'h02, 1'b0, len);
    check("even_len",      len, 513);
    check("even_writes",   log_a.size(), 256);
    check("even_first_rd", int'(first_rd), 16'h0200);
    check("even_addr_seq", dma_bad, 0);
    check("even_first_wr", int'(log_a[0]), 8'h20);
    check("even_data",     oam_errs(8'h20, 8'h02), 0);
    cpu_cycle(1'b0, 1'b1, 16'h2004, 8'h00);
    check("even_oamaddr_end", int'(bus.oam_addr), 8'h20);

    // Odd-start DMA from page 0x01
    align_parity(1'b1);
    run_dma(8'h01, 1'b0, len);
    check("odd_len",      len, exp_odd_len);
    check("odd_writes",   log_a.size(), 256);
    check("odd_addr_seq", dma_bad, 0);
    check("odd_data",     oam_errs(8'h20, 8'h01), 0);

    // Wrapping destination, register accesses during DMA ignored
    cpu_cycle(1'b1, 1'b0, 16'h2003, 8'hFC);
    align_parity(1'b0);
    run_dma(8'h03, 1'b1, len);
    check("wrap_len",      len, 513);
    check("wrap_addr_seq", dma_bad, 0);
    check("wrap_first_wr", int'(log_a[0]), 8'hFC);
    check("wrap_byte4_a",  int'(log_a[4]), 8'h00);
    check("wrap_byte4_d",  int'(log_d[4]), 8'h5D);
    check("wrap_last_wr",  int'(log_a[255]), 8'hFB);
    check("wrap_we_width", width_bad, 0);
    cpu_cycle(1'b0, 1'b1, 16'h2004, 8'h00);
    check("wrap_oamaddr_end", int'(bus.oam_addr), 8'hFC);
    check("wrap_rdata",       int'(bus.cpu_rdata), 8'h59);

    // Reset in the middle of a DMA
    align_parity(1'b0);
    start_dma(8'h04);
    for (int g = 0; g < 1000 && log_a.size() < 100; g++) cpu_cycle(1'b0, 1'b0, 16'h0000, 8'h00);
    check("mid_writes", log_a.size(), 100);
    #2;
    reset = 1'b1;
    #1;
    check("mid_rst_halt",   int'(bus.cpu_halt), 0);
    check("mid_rst_oam_we", int'(bus.oam_we),   0);
    check("mid_rst_dma_rd", int'(bus.dma_rd),   0);
    @(negedge clk);
    reset    = 1'b0;
    ce_count = 0;
    run_dma(8'h05, 1'b0, len);
    check("post_rst_first_rd", int'(first_rd), 16'h0500);
    check("post_rst_len",      len, 513);
    check("post_rst_first_wr", int'(log_a[0]), 8'h00);
    check("post_rst_data",     oam_errs(8'h00, 8'h05), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
